// File: rtl/io_pkg.sv
// Shared types and constants for the I/O store arbiter slice.
package io_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned F3_W   = 3;

    localparam logic [F3_W-1:0] F3_SB = 3'b000;
    localparam logic [F3_W-1:0] F3_SH = 3'b001;
    localparam logic [F3_W-1:0] F3_SW = 3'b010;

    localparam logic [15:0] IO_BASE_HI_DEF = 16'h1000;

    // Requester identifiers, used for the last-winner pointer and o_owner.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [F3_W-1:0]   funct3;
    } io_store_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/io_store_check.sv
// Combinational range / size / alignment check of one store.
//   st  : store under test
//   ok  : store targets the I/O window with a legal, aligned size
//   err : complement of ok
module io_store_check
    import io_pkg::*;
#(
    parameter logic [15:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
    input  io_store_t st,
    output logic      ok,
    output logic      err
);

    logic range_ok;
    logic size_align_ok;
    logic unused_bits;

    assign range_ok = (st.addr[31:16] == IO_BASE_HI);

    always_comb begin
        size_align_ok = 1'b0;
        case (st.funct3)
            F3_SB:   size_align_ok = 1'b1;
            F3_SH:   size_align_ok = (st.addr[0] == 1'b0);
            F3_SW:   size_align_ok = (st.addr[1:0] == 2'b00);
            default: size_align_ok = 1'b0;
        endcase
    end

    assign ok  = range_ok && size_align_ok;
    assign err = !ok;

    // Data and mid address bits do not affect legality.
    assign unused_bits = ^{st.data, st.addr[15:2]};

endmodule

// File: rtl/io_store_arbiter.sv
// Round-robin arbiter for the memory-mapped output-store port, shared by the
// CPU store path (requester 0) and the debug bridge (requester 1). Debug may
// hold the port for up to MAX_LOCK consecutive grants.
//   i_clk, i_reset            : clock, synchronous active-low reset
//   i_cpu_* / o_cpu_gnt       : CPU store request and same-cycle grant
//   i_dbg_* / o_dbg_gnt       : debug store request, lock, same-cycle grant
//   o_io_addr .. o_ctrl_kill  : registered store to the output buffer
//   o_err                     : pulse, previous cycle's granted store rejected
//   o_owner                   : requester of the store on the output
module io_store_arbiter
    import io_pkg::*;
#(
    parameter logic [15:0] IO_BASE_HI = IO_BASE_HI_DEF,
    parameter int unsigned MAX_LOCK   = 4,
    parameter int unsigned LCNT_W     = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic [F3_W-1:0]   i_cpu_funct3,
    output logic              o_cpu_gnt,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    input  logic [F3_W-1:0]   i_dbg_funct3,
    input  logic              i_dbg_lock,
    output logic              o_dbg_gnt,
    output logic [ADDR_W-1:0] o_io_addr,
    output logic [DATA_W-1:0] o_st_data,
    output logic [F3_W-1:0]   o_funct3,
    output logic              o_mem_write,
    output logic              o_io_valid,
    output logic              o_ctrl_valid,
    output logic              o_ctrl_bubble,
    output logic              o_ctrl_kill,
    output logic              o_err,
    output logic              o_owner
);

    localparam logic [LCNT_W-1:0] MAX_CNT = LCNT_W'(MAX_LOCK);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [LCNT_W-1:0] cnt_q, cnt_d;
    logic              cpu_gnt, dbg_gnt, any_gnt;
    io_store_t         sel;
    logic              st_ok, st_err;

    // Arbitration state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ARB;
            last_q  <= OWN_DBG;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decision and next arbitration state.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (i_reset) begin
            case (state_q)
                ARB: begin
                    if (i_cpu_req && (!i_dbg_req || (last_q == OWN_DBG))) begin
                        cpu_gnt = 1'b1;
                        last_d  = OWN_CPU;
                    end else if (i_dbg_req) begin
                        dbg_gnt = 1'b1;
                        last_d  = OWN_DBG;
                        if (i_dbg_lock) begin
                            state_d = LOCKED;
                            cnt_d   = LCNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (i_dbg_req && (cnt_q < MAX_CNT)) begin
                        dbg_gnt = 1'b1;
                        last_d  = OWN_DBG;
                        cnt_d   = cnt_q + 1'b1;
                        if (!i_dbg_lock) begin
                            state_d = ARB;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Burst over or debug went idle: CPU may take this cycle.
                        cpu_gnt = i_cpu_req;
                        state_d = ARB;
                        cnt_d   = '0;
                        if (i_dbg_req) begin
                            // Burst exhausted: CPU must also win the next tie.
                            last_d = OWN_DBG;
                        end else if (i_cpu_req) begin
                            last_d = OWN_CPU;
                        end
                    end
                end
                default: begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_cpu_gnt = cpu_gnt;
    assign o_dbg_gnt = dbg_gnt;
    assign any_gnt   = cpu_gnt || dbg_gnt;

    assign sel = dbg_gnt ? io_store_t'{addr: i_dbg_addr, data: i_dbg_wdata, funct3: i_dbg_funct3}
                         : io_store_t'{addr: i_cpu_addr, data: i_cpu_wdata, funct3: i_cpu_funct3};

    io_store_check #(
        .IO_BASE_HI (IO_BASE_HI)
    ) u_check (
        .st  (sel),
        .ok  (st_ok),
        .err (st_err)
    );

    // Single registered output stage; rejected stores leave the payload untouched.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_io_addr     <= '0;
            o_st_data     <= '0;
            o_funct3      <= '0;
            o_mem_write   <= 1'b0;
            o_io_valid    <= 1'b0;
            o_ctrl_valid  <= 1'b0;
            o_ctrl_bubble <= 1'b1;
            o_err         <= 1'b0;
            o_owner       <= OWN_CPU;
        end else begin
            o_mem_write   <= any_gnt && st_ok;
            o_io_valid    <= any_gnt && st_ok;
            o_ctrl_valid  <= any_gnt && st_ok;
            o_ctrl_bubble <= !(any_gnt && st_ok);
            o_err         <= any_gnt && st_err;
            if (any_gnt) begin
                o_owner <= dbg_gnt;
            end
            if (any_gnt && st_ok) begin
                o_io_addr <= sel.addr;
                o_st_data <= sel.data;
                o_funct3  <= sel.funct3;
            end
        end
    end

    assign o_ctrl_kill = 1'b0;

endmodule

// File: tb/tb_io_store_arbiter.sv
module tb_io_store_arbiter;

    localparam int unsigned MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dbg_req, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [2:0]  cpu_funct3, dbg_funct3;
    logic        cpu_gnt, dbg_gnt;
    logic [31:0] io_addr, st_data;
    logic [2:0]  funct3;
    logic        mem_write, io_valid, ctrl_valid, ctrl_bubble, ctrl_kill, err, owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_store_arbiter #(.IO_BASE_HI(16'h1000), .MAX_LOCK(MAX_LOCK), .LCNT_W(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .i_cpu_funct3(cpu_funct3), .o_cpu_gnt(cpu_gnt),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .i_dbg_funct3(dbg_funct3), .i_dbg_lock(dbg_lock), .o_dbg_gnt(dbg_gnt),
        .o_io_addr(io_addr), .o_st_data(st_data), .o_funct3(funct3),
        .o_mem_write(mem_write), .o_io_valid(io_valid), .o_ctrl_valid(ctrl_valid),
        .o_ctrl_bubble(ctrl_bubble), .o_ctrl_kill(ctrl_kill), .o_err(err), .o_owner(owner)
    );

    // Downstream output buffer (LED/hex register) fed by the arbiter.
    logic [31:0] obuf;
    always_ff @(posedge clk) begin
        if (!rst) obuf <= 32'h7F7F7F7F;
        else if (mem_write) obuf <= st_data;
    end

    // Reference model state.
    bit          m_locked;
    int          m_burst;
    bit          m_last_dbg;
    logic [31:0] e_addr, e_data;
    logic [2:0]  e_f3;
    logic        e_wr, e_err, e_owner;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [2:0] f);
        if (a[31:16] != 16'h1000) return 0;
        if (f == 3'd0) return 1;
        if (f == 3'd1) return a[0] == 1'b0;
        if (f == 3'd2) return a[1:0] == 2'b00;
        return 0;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_burst = 0; m_last_dbg = 1;
        e_addr = 0; e_data = 0; e_f3 = 0; e_wr = 0; e_err = 0; e_owner = 0;
    endtask

    // One clock cycle: check last cycle's registered result, drive inputs,
    // check the combinational grant, advance the model.
    task automatic step(input logic r, input logic cr, input logic [31:0] ca, input logic [31:0] cd,
                        input logic [2:0] cf, input logic dr, input logic [31:0] da,
                        input logic [31:0] dd, input logic [2:0] df, input logic dl,
                        input logic cb, input logic [31:0] eb);
        bit gc, gd, ok;
        @(negedge clk);
        chk("io_addr", io_addr, e_addr);
        chk("st_data", st_data, e_data);
        chk("funct3", 32'(funct3), 32'(e_f3));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("io_valid", 32'(io_valid), 32'(e_wr));
        chk("ctrl_valid", 32'(ctrl_valid), 32'(e_wr));
        chk("ctrl_bubble", 32'(ctrl_bubble), 32'(!e_wr));
        chk("ctrl_kill", 32'(ctrl_kill), 32'd0);
        chk("err", 32'(err), 32'(e_err));
        chk("owner", 32'(owner), 32'(e_owner));
        if (cb) chk("out_buffer", obuf, eb);
        rst = r; cpu_req = cr; cpu_addr = ca; cpu_wdata = cd; cpu_funct3 = cf;
        dbg_req = dr; dbg_addr = da; dbg_wdata = dd; dbg_funct3 = df; dbg_lock = dl;
        #1;
        // Who should win this cycle.
        gc = 0; gd = 0;
        if (r) begin
            if (m_locked && dr && m_burst < MAX_LOCK) gd = 1;
            else if (m_locked) gc = cr;
            else if (cr && dr) begin gc = m_last_dbg; gd = !m_last_dbg; end
            else begin gc = cr; gd = dr; end
        end
        chk("cpu_gnt", 32'(cpu_gnt), 32'(gc));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(gd));
        if (!r) begin
            model_reset();
        end else begin
            if (m_locked) begin
                if (gd) begin
                    m_burst++;
                    m_last_dbg = 1;
                    if (!dl) begin m_locked = 0; m_burst = 0; end
                end else begin
                    m_locked = 0; m_burst = 0;
                    if (dr) m_last_dbg = 1;
                    else if (gc) m_last_dbg = 0;
                end
            end else begin
                if (gc) m_last_dbg = 0;
                if (gd) begin
                    m_last_dbg = 1;
                    if (dl) begin m_locked = 1; m_burst = 1; end
                end
            end
            ok = gd ? legal(da, df) : legal(ca, cf);
            e_wr  = (gc || gd) && ok;
            e_err = (gc || gd) && !ok;
            if (gc || gd) e_owner = gd;
            if (e_wr) begin
                e_addr = gd ? da : ca;
                e_data = gd ? dd : cd;
                e_f3   = gd ? df : cf;
            end
        end
    endtask

    typedef struct {
        logic        r, cr;
        logic [31:0] ca, cd;
        logic [2:0]  cf;
        logic        dr;
        logic [31:0] da, dd;
        logic [2:0]  df;
        logic        dl, eg_c, eg_d, cb;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic cr, input logic [31:0] ca, input logic [31:0] cd,
                                input logic [2:0] cf, input logic dr, input logic [31:0] da,
                                input logic [31:0] dd, input logic [2:0] df, input logic dl,
                                input logic gc, input logic gd, input logic cb, input logic [31:0] eb);
        vec_t v;
        v.r = r; v.cr = cr; v.ca = ca; v.cd = cd; v.cf = cf;
        v.dr = dr; v.da = da; v.dd = dd; v.df = df; v.dl = dl;
        v.eg_c = gc; v.eg_d = gd; v.cb = cb; v.eb = eb;
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rd;
        rst = 0; cpu_req = 0; dbg_req = 0; dbg_lock = 0;
        cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 0;
        dbg_addr = 0; dbg_wdata = 0; dbg_funct3 = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Directed vectors: reset, single CPU store, alternation, lock burst,
        // rejected stores, reset mid-lock.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1000_0000, 32'h1, 2, 1, 32'h1000_0000, 32'h2, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 32'h1000_0010, 32'h1111_1111, 2, 1, 32'h1000_0022, 32'h2222, 1, 0,
                             (i % 2) == 0, (i % 2) == 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h1000_0030, 32'hA0, 2, 1, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 32'h1000_0040, 32'hC0, 2, 1, 32'h1000_0030, 32'hA1 + i, 2, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_0040, 32'hC1, 2, 1, 32'h1000_0030, 32'hAF, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_0044, 32'hC2, 2, 1, 32'h1000_0034, 32'hB0, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_0048, 32'hC3, 2, 1, 32'h1000_0038, 32'hB1, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_004C, 32'hC4, 2, 1, 32'h1000_003C, 32'hB2, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_2002, 32'h55, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h2000_0000, 32'h66, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7F7F_7F7F));
        tbl.push_back(mk(1, 1, 32'h1000_1000, 32'h77, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7F7F_7F7F));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h1000_0050, 32'hD0, 2, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1000_0060, 32'hE0, 2, 1, 32'h1000_0054, 32'hD1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1000_0060, 32'hE0, 2, 1, 32'h1000_0054, 32'hD1, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].cr, tbl[k].ca, tbl[k].cd, tbl[k].cf,
                 tbl[k].dr, tbl[k].da, tbl[k].dd, tbl[k].df, tbl[k].dl, tbl[k].cb, tbl[k].eb);
            chk($sformatf("vec%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(tbl[k].eg_c));
            chk($sformatf("vec%0d_dbg_gnt", k), 32'(dbg_gnt), 32'(tbl[k].eg_d));
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] fc, fd;
            ra = {($urandom_range(0, 3) != 0) ? 16'h1000 : 16'($urandom), 16'($urandom)};
            rd = {($urandom_range(0, 3) != 0) ? 16'h1000 : 16'($urandom), 16'($urandom)};
            fc = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            fd = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, ra, $urandom, fc,
                 $urandom_range(0, 9) < 7, rd, $urandom, fd, 1'($urandom), 0, 0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
